bus_controller: RTL and testbench
=================================

# bus_controller

System-bus controller directly downstream of the `cpu` memory port. Decodes every CPU access and serves high RAM (0xFF80–0xFFFE) internally. Owns the OAM DMA register (0xFF46) and the 160-byte OAM DMA engine. Forwards all other accesses to the external system bus and arbitrates that bus between the CPU and DMA.

## Interface
Parameters:
- `DMA_LEN`, 160: bytes per OAM DMA transfer.

Ports:
- `clk`  in  1  system clock (4 MHz).
- `reset`  in  1  asynchronous, active-low reset.
- `t_cycle`  in  2  shared T-cycle phase, 0..3. One M-cycle = 4 clocks.
- `cpu_addr`  in  16  CPU bus address.
- `cpu_enable`  in  1  CPU access valid this M-cycle.
- `cpu_write`  in  1  CPU write (else read).
- `cpu_wdata`  in  8  CPU write data.
- `cpu_rdata`  out  8  read data returned to the CPU.
- `bus_addr`  out  16  external bus address.
- `bus_enable`  out  1  external bus access valid.
- `bus_write`  out  1  external bus write.
- `bus_wdata`  out  8  external bus write data.
- `bus_rdata`  in  8  external bus read data.
- `oam_addr`  out  8  OAM write index.
- `oam_write`  out  1  OAM write strobe.
- `oam_wdata`  out  8  OAM write data.
- `dma_active`  out  1  DMA state is not IDLE.

## Operation
- Decode:
  - 0xFF80–0xFFFE goes to internal HRAM (127×8).
  - 0xFF46 goes to the DMA source register.
  - Everything else goes to the external bus.
- HRAM read is combinational onto `cpu_rdata`. HRAM is always accessible, including during DMA.
- FF46:
  - Read returns the last written value.
  - Write latches `src` and starts or restarts DMA.
- Page remap: if `src` ≥ 0xE0, the effective source page is `src` − 0x20.
- DMA FSM:
  - IDLE → START on a committed FF46 write.
  - START lasts 1 M-cycle with no bus use, then goes to XFER with `idx`=0.
  - XFER lasts 1 M-cycle per byte:
    - `bus_addr`={page,`idx`}, `bus_enable`=1, `bus_write`=0.
    - At t_cycle 3: `oam_write`=1, `oam_addr`=`idx`, `oam_wdata`=`bus_rdata`.
    - `idx` increments at the end of the M-cycle.
    - After `idx`=`DMA_LEN`−1 commits, return to IDLE.
- FF46 write during START or XFER: latch new `src`, go to START, `idx`=0. `dma_active` stays 1.
- CPU external access during XFER (bus locked): reads return 0xFF, writes are dropped, and the bus carries the DMA address.
- `cpu_rdata` for an unselected/idle access is 0xFF.

## Timing
- All state, HRAM, `src` and `idx` updates commit on the `clk` edge where `t_cycle`==3.
- DMA latency:
  - FF46 write commits at the end of M-cycle n.
  - START = n+1.
  - Bytes 0..159 transfer in n+2..n+161.
  - `dma_active` is high from n+1 through n+161 and low from n+162.
- `oam_write` is high only during t_cycle 3 of XFER M-cycles.
- Reset (asynchronous, takes effect immediately, including mid-transfer):
  - state=IDLE, `idx`=0, `src`=0xFF.
  - Outputs: `dma_active`=0, `oam_write`=0, `bus_enable`=0, `bus_write`=0, `cpu_rdata`=0xFF, `bus_addr`=0, `oam_addr`=0, `oam_wdata`=0.
- HRAM contents are not reset.
- The CPU's own FF46 write is never blocked, including during XFER.

## Configuration
- `BUS_CTRL_DMA_LOCK_EN` defined: XFER locks the bus as described in Operation.
- `BUS_CTRL_DMA_LOCK_EN` undefined:
  - A CPU external access in an XFER M-cycle wins the bus and completes normally.
  - DMA stalls that M-cycle: no `oam_write`, and `idx` holds.
  - Transfer length therefore grows by one M-cycle per stolen cycle.
  - HRAM and FF46 accesses never stall DMA.

## Test plan
- Write 0xC0 to FF46 with bus memory pattern byte[i]=i^0x5A → OAM[0..159]=i^0x5A in order. Exactly 160 `oam_write` pulses. `dma_active` high for 161 M-cycles.
- Write FF46=0xE1 → bus reads 0xC100–0xC19F. FF46 reads back 0xE1.
- During XFER, CPU writes 0x33 to FF90 then reads it back → returns 0x33. CPU read of 0x8000 → 0xFF with lock; with lock undefined → real data, and DMA completes one M-cycle late.
- Rewrite FF46=0xD0 at byte 80 → START again, then `idx` restarts at 0. Final OAM holds the 0xD000 page. Total active = 81+161 M-cycles.
- Assert `reset` low at byte 50 → `dma_active` and `oam_write` drop immediately. After release, state is IDLE and FF46 reads 0xFF.

Source files
------------

// File: rtl/bus_controller.sv
// -----------------------------------------------------------------------------
// bus_controller
//
// System-bus controller sitting directly behind the CPU memory port.
//   - 0xFF80..0xFFFE : internal high RAM (127 x 8), always accessible.
//   - 0xFF46         : OAM DMA source register; a write starts/restarts DMA.
//   - everything else: forwarded to the external system bus.
// The OAM DMA engine copies DMA_LEN bytes from page {src} (pages 0xE0..0xFF
// are remapped down by 0x20) into OAM, one byte per M-cycle.
//
// Build option:
//   BUS_CTRL_DMA_LOCK_EN  defined   : during XFER the bus belongs to DMA; CPU
//                                     external reads return 0xFF and writes
//                                     are dropped.
//                         undefined : a CPU external access in an XFER
//                                     M-cycle wins the bus and DMA stalls for
//                                     that M-cycle.
//
// Ports:
//   clk, reset                 clock and asynchronous active-low reset
//   t_cycle[1:0]               T-cycle phase; state commits when t_cycle==3
//   cpu_addr/enable/write/wdata/rdata   CPU memory port
//   bus_addr/enable/write/wdata/rdata   external system bus
//   oam_addr/write/wdata       OAM write port driven by the DMA engine
//   dma_active                 DMA engine is not idle
// -----------------------------------------------------------------------------
module bus_controller #(
    parameter int DMA_LEN = 160
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  t_cycle,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_enable,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] bus_addr,
    output logic        bus_enable,
    output logic        bus_write,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic [7:0]  oam_addr,
    output logic        oam_write,
    output logic [7:0]  oam_wdata,
    output logic        dma_active
);

`ifdef BUS_CTRL_DMA_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    localparam logic [7:0] IDX_LAST = 8'(DMA_LEN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } dma_state_t;

    dma_state_t state_q, state_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] src_q;
    logic [7:0] page;

    logic [7:0] hram [0:126];
    logic [6:0] hram_idx;

    logic commit;
    logic hram_sel, reg_sel, ext_sel;
    logic cpu_ext, ff46_wr, xfer;
    logic steal, bus_locked, dma_bus;

    // ---------------------------------------------------------------- decode
    assign commit   = (t_cycle == 2'd3);
    assign hram_sel = (cpu_addr >= 16'hFF80) && (cpu_addr <= 16'hFFFE);
    assign reg_sel  = (cpu_addr == 16'hFF46);
    assign ext_sel  = !hram_sel && !reg_sel;
    assign hram_idx = cpu_addr[6:0];

    assign cpu_ext  = cpu_enable && ext_sel;
    assign ff46_wr  = cpu_enable && cpu_write && reg_sel;
    assign xfer     = (state_q == XFER);

    // Without the lock the CPU takes the bus and DMA stalls; with the lock
    // the CPU access is blocked and DMA keeps the bus.
    assign steal      = xfer && cpu_ext && !LOCK_EN;
    assign bus_locked = xfer && cpu_ext && LOCK_EN;
    assign dma_bus    = xfer && !steal;

    // Pages 0xE0..0xFF mirror work RAM at 0xC0..0xDF.
    assign page = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;

    assign dma_active = (state_q != IDLE);

    // ---------------------------------------------------------- state update
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 8'd0;
            src_q   <= 8'hFF;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (commit && ff46_wr) begin
                src_q <= cpu_wdata;
            end
        end
    end

    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (commit) begin
            if (ff46_wr) begin
                // CPU write to FF46 always wins, restarting the transfer.
                state_d = START;
                idx_d   = 8'd0;
            end else begin
                case (state_q)
                    START: begin
                        state_d = XFER;
                        idx_d   = 8'd0;
                    end
                    XFER: begin
                        if (!steal) begin
                            if (idx_q == IDX_LAST) begin
                                state_d = IDLE;
                                idx_d   = 8'd0;
                            end else begin
                                idx_d = idx_q + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------ HRAM
    // NOTE: memory arrays are deliberately left out of reset; their contents
    // are undefined until written, and a reset would only cost a huge fan-out.
    always_ff @(posedge clk) begin
        if (reset && commit && cpu_enable && cpu_write && hram_sel) begin
            hram[hram_idx] <= cpu_wdata;
        end
    end

    // --------------------------------------------------------------- outputs
    always_comb begin
        cpu_rdata  = 8'hFF;
        bus_addr   = 16'h0000;
        bus_enable = 1'b0;
        bus_write  = 1'b0;
        bus_wdata  = 8'h00;
        oam_addr   = 8'h00;
        oam_write  = 1'b0;
        oam_wdata  = 8'h00;
        if (reset) begin
            if (cpu_enable && !cpu_write) begin
                if (hram_sel) begin
                    cpu_rdata = hram[hram_idx];
                end else if (reg_sel) begin
                    cpu_rdata = src_q;
                end else if (!bus_locked) begin
                    cpu_rdata = bus_rdata;
                end
            end

            if (dma_bus) begin
                bus_addr   = {page, idx_q};
                bus_enable = 1'b1;
            end else if (cpu_ext) begin
                bus_addr   = cpu_addr;
                bus_enable = 1'b1;
                bus_write  = cpu_write;
                bus_wdata  = cpu_wdata;
            end

            if (dma_bus && commit) begin
                oam_write = 1'b1;
                oam_addr  = idx_q;
                oam_wdata = bus_rdata;
            end
        end
    end

endmodule

// File: tb/tb_bus_controller.sv
// -----------------------------------------------------------------------------
// tb_bus_controller
//
// Self-checking bench for bus_controller. A flat 64 KiB array stands in for
// the external bus memory; the expected OAM image, DMA duration and pulse
// counts are derived from the transfer rules (source page, byte count, one
// M-cycle per byte) rather than from the RTL structure. Follows the
// BUS_CTRL_DMA_LOCK_EN build option for the CPU-during-XFER expectations.
// -----------------------------------------------------------------------------
module tb_bus_controller;

    localparam int DMA_LEN = 160;

`ifdef BUS_CTRL_DMA_LOCK_EN
    localparam bit LOCK = 1'b1;
`else
    localparam bit LOCK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  t_cycle = 2'd0;
    logic [15:0] cpu_addr;
    logic        cpu_enable;
    logic        cpu_write;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic [15:0] bus_addr;
    logic        bus_enable;
    logic        bus_write;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic [7:0]  oam_addr;
    logic        oam_write;
    logic [7:0]  oam_wdata;
    logic        dma_active;

    bus_controller #(.DMA_LEN(DMA_LEN)) dut (
        .clk        (clk),
        .reset      (reset),
        .t_cycle    (t_cycle),
        .cpu_addr   (cpu_addr),
        .cpu_enable (cpu_enable),
        .cpu_write  (cpu_write),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .bus_addr   (bus_addr),
        .bus_enable (bus_enable),
        .bus_write  (bus_write),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .oam_addr   (oam_addr),
        .oam_write  (oam_write),
        .oam_wdata  (oam_wdata),
        .dma_active (dma_active)
    );

    always #5 clk = ~clk;
    always @(posedge clk) t_cycle <= t_cycle + 2'd1;

    // External memory model.
    logic [7:0] mem [0:65535];
    always_comb bus_rdata = mem[bus_addr];

    // Reference state.
    logic [7:0] hram_ref [0:126];

    int checks = 0;
    int errors = 0;

    // Monitor: observes OAM writes and DMA activity once per M-cycle.
    int          active_cnt = 0;
    int          pulse_cnt  = 0;
    int          bad_pulse  = 0;
    logic [7:0]  oam_ref  [0:255];
    logic [15:0] addr_log [0:255];

    always @(negedge clk) begin
        if (t_cycle == 2'd3) begin
            if (dma_active) active_cnt <= active_cnt + 1;
            if (oam_write) begin
                oam_ref[oam_addr]  <= oam_wdata;
                addr_log[oam_addr] <= bus_addr;
                pulse_cnt          <= pulse_cnt + 1;
            end
        end else if (oam_write) begin
            bad_pulse <= bad_pulse + 1;
        end
    end

    // Values sampled at t_cycle 3 of the last M-cycle issued.
    logic [7:0]  s_rdata;
    logic [15:0] s_baddr;
    logic        s_ben;
    logic        s_bwr;
    logic [7:0]  s_bwdata;
    logic        s_act;
    logic        s_oamw;

    // One CPU M-cycle: drive after the commit edge, sample late in t_cycle 3.
    task automatic cycle(input logic en, input logic wr,
                         input logic [15:0] addr, input logic [7:0] wdata);
        do begin
            @(posedge clk);
            #1;
        end while (t_cycle != 2'd0);
        cpu_enable = en;
        cpu_write  = wr;
        cpu_addr   = addr;
        cpu_wdata  = wdata;
        repeat (4) @(negedge clk);
        #1;
        s_rdata  = cpu_rdata;
        s_baddr  = bus_addr;
        s_ben    = bus_enable;
        s_bwr    = bus_write;
        s_bwdata = bus_wdata;
        s_act    = dma_active;
        s_oamw   = oam_write;
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    task automatic wr(input logic [15:0] addr, input logic [7:0] data);
        cycle(1'b1, 1'b1, addr, data);
    endtask

    task automatic rd(input logic [15:0] addr);
        cycle(1'b1, 1'b0, addr, 8'h00);
    endtask

    task automatic wait_done(input string name, input int max_cycles);
        int n;
        n = 0;
        do begin
            idle();
            n++;
        end while (s_act && n < max_cycles);
        checks++;
        if (s_act) begin
            errors++;
            $display("FAIL %s timeout: dma_active still 1 after %0d M-cycles", name, n);
        end
    endtask

    task automatic check_oam_page(input string name, input logic [15:0] base);
        for (int i = 0; i < DMA_LEN; i++) begin
            checks++;
            if (oam_ref[i] !== mem[base + 16'(i)]) begin
                errors++;
                $display("FAIL %s oam[%0d]: got %h expected %h", name, i, oam_ref[i], mem[base + 16'(i)]);
            end
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ----------------------------------------------------------------- tests
    task automatic test_reset();
        reset      = 1'b0;
        cpu_enable = 1'b0;
        cpu_write  = 1'b0;
        cpu_addr   = 16'h0000;
        cpu_wdata  = 8'h00;
        repeat (6) @(negedge clk);
        checks++; if (dma_active !== 1'b0)    begin errors++; $display("FAIL reset dma_active: got %b expected 0", dma_active); end
        checks++; if (oam_write !== 1'b0)     begin errors++; $display("FAIL reset oam_write: got %b expected 0", oam_write); end
        checks++; if (bus_enable !== 1'b0)    begin errors++; $display("FAIL reset bus_enable: got %b expected 0", bus_enable); end
        checks++; if (bus_write !== 1'b0)     begin errors++; $display("FAIL reset bus_write: got %b expected 0", bus_write); end
        checks++; if (cpu_rdata !== 8'hFF)    begin errors++; $display("FAIL reset cpu_rdata: got %h expected ff", cpu_rdata); end
        checks++; if (bus_addr !== 16'h0000)  begin errors++; $display("FAIL reset bus_addr: got %h expected 0000", bus_addr); end
        checks++; if (oam_addr !== 8'h00)     begin errors++; $display("FAIL reset oam_addr: got %h expected 00", oam_addr); end
        checks++; if (oam_wdata !== 8'h00)    begin errors++; $display("FAIL reset oam_wdata: got %h expected 00", oam_wdata); end
        reset = 1'b1;
        rd(16'hFF46);
        checks++; if (s_rdata !== 8'hFF) begin errors++; $display("FAIL reset ff46 read: got %h expected ff", s_rdata); end
    endtask

    task automatic test_hram_and_bus();
        logic [6:0]  r;
        logic [15:0] a;
        logic [7:0]  d;
        for (int i = 0; i < 127; i++) begin
            d = 8'($urandom);
            hram_ref[i] = d;
            wr(16'hFF80 + 16'(i), d);
        end
        for (int k = 0; k < 16; k++) begin
            r = 7'($urandom_range(0, 126));
            rd(16'hFF80 + 16'(r));
            checks++;
            if (s_rdata !== hram_ref[r]) begin
                errors++;
                $display("FAIL hram read ff%h: got %h expected %h", 8'h80 + 8'(r), s_rdata, hram_ref[r]);
            end
        end
        for (int k = 0; k < 4; k++) begin
            a = 16'($urandom_range(0, 16'hFEFF));
            rd(a);
            checks++;
            if (s_rdata !== mem[a] || s_baddr !== a || s_ben !== 1'b1) begin
                errors++;
                $display("FAIL ext read %h: got data %h addr %h en %b expected %h %h 1", a, s_rdata, s_baddr, s_ben, mem[a], a);
            end
        end
        a = 16'($urandom_range(0, 16'hFEFF));
        d = 8'($urandom);
        wr(a, d);
        checks++;
        if (s_bwr !== 1'b1 || s_bwdata !== d || s_baddr !== a) begin
            errors++;
            $display("FAIL ext write: got we %b data %h addr %h expected 1 %h %h", s_bwr, s_bwdata, s_baddr, d, a);
        end
        idle();
        checks++;
        if (s_rdata !== 8'hFF || s_ben !== 1'b0) begin
            errors++;
            $display("FAIL idle cycle: got rdata %h bus_en %b expected ff 0", s_rdata, s_ben);
        end
    endtask

    task automatic test_dma_basic();
        int a0, p0, b0;
        for (int i = 0; i < 256; i++) mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'h5A;
        a0 = active_cnt; p0 = pulse_cnt; b0 = bad_pulse;
        wr(16'hFF46, 8'hC0);
        idle();
        checks++;
        if (s_act !== 1'b1 || s_ben !== 1'b0) begin
            errors++;
            $display("FAIL dma start cycle: got active %b bus_en %b expected 1 0", s_act, s_ben);
        end
        idle();
        checks++;
        if (s_baddr !== 16'hC000 || s_ben !== 1'b1 || s_bwr !== 1'b0 || s_oamw !== 1'b1) begin
            errors++;
            $display("FAIL dma first byte: got addr %h en %b we %b oamw %b expected c000 1 0 1", s_baddr, s_ben, s_bwr, s_oamw);
        end
        wait_done("dma_basic", 400);
        check_int("dma_basic active M-cycles", active_cnt - a0, DMA_LEN + 1);
        check_int("dma_basic oam pulses", pulse_cnt - p0, DMA_LEN);
        check_int("dma_basic off-phase oam pulses", bad_pulse - b0, 0);
        check_oam_page("dma_basic", 16'hC000);
    endtask

    task automatic test_remap();
        int p0;
        for (int i = 0; i < 256; i++) mem[16'hC100 + 16'(i)] = 8'($urandom);
        p0 = pulse_cnt;
        wr(16'hFF46, 8'hE1);
        rd(16'hFF46);
        checks++;
        if (s_rdata !== 8'hE1) begin
            errors++;
            $display("FAIL remap ff46 readback: got %h expected e1", s_rdata);
        end
        wait_done("remap", 400);
        check_int("remap oam pulses", pulse_cnt - p0, DMA_LEN);
        for (int i = 0; i < DMA_LEN; i++) begin
            checks++;
            if (addr_log[i] !== 16'hC100 + 16'(i)) begin
                errors++;
                $display("FAIL remap bus addr byte %0d: got %h expected %h", i, addr_log[i], 16'hC100 + 16'(i));
            end
        end
        check_oam_page("remap", 16'hC100);
    endtask

    task automatic test_cpu_during_xfer();
        int a0, p0;
        logic [7:0]  exp_rd;
        logic [15:0] exp_addr;
        for (int i = 0; i < 256; i++) mem[16'hC000 + 16'(i)] = 8'(i) ^ 8'hA5;
        mem[16'h8000] = 8'hA7;
        a0 = active_cnt; p0 = pulse_cnt;
        wr(16'hFF46, 8'hC0);               // M-cycle n
        repeat (10) idle();                // n+1 .. n+10
        wr(16'hFF90, 8'h33);               // n+11, byte 9
        hram_ref[16] = 8'h33;
        rd(16'hFF90);                      // n+12, byte 10
        checks++;
        if (s_rdata !== 8'h33 || s_act !== 1'b1) begin
            errors++;
            $display("FAIL xfer hram readback: got %h active %b expected 33 1", s_rdata, s_act);
        end
        rd(16'h8000);                      // n+13, byte 11 (stalled without lock)
        exp_rd   = LOCK ? 8'hFF : 8'hA7;
        exp_addr = LOCK ? 16'hC00B : 16'h8000;
        checks++;
        if (s_rdata !== exp_rd || s_baddr !== exp_addr || s_oamw !== LOCK) begin
            errors++;
            $display("FAIL xfer ext read: got data %h addr %h oamw %b expected %h %h %b", s_rdata, s_baddr, s_oamw, exp_rd, exp_addr, LOCK);
        end
        wait_done("cpu_xfer", 400);
        check_int("cpu_xfer active M-cycles", active_cnt - a0, LOCK ? DMA_LEN + 1 : DMA_LEN + 2);
        check_int("cpu_xfer oam pulses", pulse_cnt - p0, DMA_LEN);
        check_oam_page("cpu_xfer", 16'hC000);
        rd(16'hFF90);
        checks++;
        if (s_rdata !== 8'h33) begin
            errors++;
            $display("FAIL hram after xfer: got %h expected 33", s_rdata);
        end
    endtask

    task automatic test_restart();
        int a0, p0;
        for (int i = 0; i < 256; i++) mem[16'hD000 + 16'(i)] = 8'($urandom);
        a0 = active_cnt; p0 = pulse_cnt;
        wr(16'hFF46, 8'hC0);               // n
        repeat (80) idle();                // n+1 .. n+80, bytes 0..78
        wr(16'hFF46, 8'hD0);               // n+81, byte 79 still transfers
        idle();
        checks++;
        if (s_act !== 1'b1 || s_ben !== 1'b0) begin
            errors++;
            $display("FAIL restart start cycle: got active %b bus_en %b expected 1 0", s_act, s_ben);
        end
        idle();
        checks++;
        if (s_baddr !== 16'hD000 || s_oamw !== 1'b1) begin
            errors++;
            $display("FAIL restart first byte: got addr %h oamw %b expected d000 1", s_baddr, s_oamw);
        end
        wait_done("restart", 500);
        check_int("restart active M-cycles", active_cnt - a0, 81 + DMA_LEN + 1);
        check_int("restart oam pulses", pulse_cnt - p0, 80 + DMA_LEN);
        check_oam_page("restart", 16'hD000);
    endtask

    task automatic test_reset_mid();
        int p0;
        wr(16'hFF46, 8'hC0);
        repeat (51) idle();
        idle();                            // byte 50, sampled in t_cycle 3
        checks++;
        if (s_oamw !== 1'b1 || s_act !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid pre: got oamw %b active %b expected 1 1", s_oamw, s_act);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (dma_active !== 1'b0 || oam_write !== 1'b0 || bus_enable !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid async: got active %b oamw %b bus_en %b expected 0 0 0", dma_active, oam_write, bus_enable);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        p0 = pulse_cnt;
        idle();
        checks++;
        if (s_act !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid idle after release: got active %b expected 0", s_act);
        end
        rd(16'hFF46);
        checks++;
        if (s_rdata !== 8'hFF) begin
            errors++;
            $display("FAIL reset_mid ff46 read: got %h expected ff", s_rdata);
        end
        repeat (4) idle();
        check_int("reset_mid pulses after release", pulse_cnt - p0, 0);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'($urandom);
        for (int i = 0; i < 256; i++) begin
            oam_ref[i]  = 8'h00;
            addr_log[i] = 16'h0000;
        end
        test_reset();
        test_hram_and_bus();
        test_dma_basic();
        test_remap();
        test_cpu_during_xfer();
        test_restart();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
